dmem_pair_streamer: RTL and testbench

Sequencer for the 512 x 16 constant data memory feeding the FPU test datapath. On a start command it walks the memory from a programmable base address, reads consecutive words two at a time and presents each pair as an operand pair (A, B) on a valid/ready handshake. The memory is a combinational read port (address in, word out the same cycle). The block sits between that memory and the operand inputs of the FPU/integer execution unit.

---
 rtl/dmem_pair_streamer.sv | 138 +++++++++++++
 tb/tb_dmem_pair_streamer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_pair_streamer.sv
// -----------------------------------------------------------------------------
// dmem_pair_streamer
//
// Walks the constant data memory from a programmable base address, reading
// consecutive words two at a time. Each pair is presented as an operand pair
// (op_a = even offset word, op_b = odd offset word) on a valid/ready handshake
// towards the FPU/integer execution unit.
//
// The memory read port is combinational: rom_q follows rom_addr in the same
// cycle. rom_addr is driven straight from the pointer register, so each fetch
// state captures the word the pointer currently addresses.
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   rst       : synchronous active-high reset
//   start     : command strobe, only honoured in IDLE
//   base      : first word address, captured with start
//   count     : number of operand pairs to emit, captured with start
//   rom_addr  : address to the data memory
//   rom_q     : data memory word for rom_addr
//   op_a      : operand A (word at even offset from base)
//   op_b      : operand B (word at odd offset from base)
//   op_valid  : op_a/op_b hold a valid pair
//   op_ready  : consumer accepts the pair when op_valid & op_ready
//   busy      : high whenever the sequencer is not idle
//   done      : one-cycle pulse at the end of a command
// -----------------------------------------------------------------------------
module dmem_pair_streamer #(
    parameter int AW = 9,
    parameter int DW = 16,
    parameter int CW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [CW-1:0] count,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_q,
    output logic [DW-1:0] op_a,
    output logic [DW-1:0] op_b,
    output logic          op_valid,
    input  logic          op_ready,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH_A = 3'd1,
        FETCH_B = 3'd2,
        PRESENT = 3'd3,
        FINISH  = 3'd4
    } state_t;

    state_t        state;
    logic [AW-1:0] ptr;
    logic [CW-1:0] remaining;
    logic [DW-1:0] a_reg;
    logic [DW-1:0] b_reg;
    logic          done_reg;

    // -------------------------------------------------------------------------
    // Sequencer FSM. done is registered and raised on the same edge that
    // enters FINISH, so it is high exactly while the FSM sits in FINISH.
    // ptr wraps naturally at 2^AW because it is only AW bits wide.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            remaining <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ptr       <= base;
                        remaining <= count;
                        if (count != '0) begin
                            state <= FETCH_A;
                        end else begin
                            // Empty command: skip straight to the done pulse.
                            state    <= FINISH;
                            done_reg <= 1'b1;
                        end
                    end
                end

                FETCH_A: begin
                    a_reg <= rom_q;
                    ptr   <= ptr + 1'b1;
                    state <= FETCH_B;
                end

                FETCH_B: begin
                    b_reg <= rom_q;
                    ptr   <= ptr + 1'b1;
                    state <= PRESENT;
                end

                PRESENT: begin
                    // Without op_ready everything holds, keeping the pair
                    // stable for the consumer.
                    if (op_ready) begin
                        remaining <= remaining - 1'b1;
                        if (remaining == CW'(1)) begin
                            state    <= FINISH;
                            done_reg <= 1'b1;
                        end else begin
                            state <= FETCH_A;
                        end
                    end
                end

                FINISH: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs are taken directly from registered state.
    assign rom_addr = ptr;
    assign op_a     = a_reg;
    assign op_b     = b_reg;
    assign op_valid = (state == PRESENT);
    assign busy     = (state != IDLE);
    assign done     = done_reg;

endmodule

// File: tb/tb_dmem_pair_streamer.sv
module tb_dmem_pair_streamer;

    localparam int AW = 9;
    localparam int DW = 16;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base;
    logic [CW-1:0] count;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_q;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic          op_valid;
    logic          op_ready;
    logic          busy;
    logic          done;

    logic [DW-1:0] rom [0:(1<<AW)-1];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign rom_q = rom[rom_addr];

    dmem_pair_streamer #(.AW(AW), .DW(DW), .CW(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base     (base),
        .count    (count),
        .rom_addr (rom_addr),
        .rom_q    (rom_q),
        .op_a     (op_a),
        .op_b     (op_b),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .busy     (busy),
        .done     (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Runs one command from IDLE, starting and ending at a falling edge.
    // Expected behaviour is derived from the command alone:
    //   pair k = (rom[base+2k], rom[base+2k+1]) modulo memory depth;
    //   after start or a handshake the next pair is valid 3 cycles later,
    //   with addresses base+2k and base+2k+1 shown in the two cycles before;
    //   while a pair is offered the pointer has advanced to base+2k+2;
    //   done follows the last handshake by one cycle, then busy drops.
    // mode: 0 = op_ready always 1, 1 = random op_ready,
    //       2 = op_ready low for the first 5 valid cycles of each pair.
    // inject: 0 = none, 1 = stray start 4 cycles in, 2 = stray start with
    //         the final handshake.
    task automatic run_cmd(input logic [AW-1:0] b, input int n, input int mode, input int inject);
        int k;
        int gap;
        int cyc;
        int stall;
        logic exp_v;
        logic [AW-1:0] ea;
        logic [AW-1:0] eaddr;

        start    = 1'b1;
        base     = b;
        count    = CW'(n);
        op_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        base  = AW'($urandom);
        count = CW'($urandom);

        if (n == 0) begin
            chk("zero_done", 32'(done), 32'd1);
            chk("zero_busy", 32'(busy), 32'd1);
            chk("zero_valid", 32'(op_valid), 32'd0);
            @(negedge clk);
            chk("zero_busy_end", 32'(busy), 32'd0);
            chk("zero_done_end", 32'(done), 32'd0);
            chk("zero_valid_end", 32'(op_valid), 32'd0);
            return;
        end

        k = 0; gap = 1; cyc = 0; stall = 0;
        while (k < n && cyc < 2000) begin
            start = 1'b0;
            exp_v = (gap >= 3);
            chk("valid", 32'(op_valid), 32'(exp_v));
            chk("busy", 32'(busy), 32'd1);
            chk("done_early", 32'(done), 32'd0);
            ea = b + AW'(2 * k);
            if (exp_v) begin
                chk("op_a", 32'(op_a), 32'(rom[ea]));
                chk("op_b", 32'(op_b), 32'(rom[AW'(ea + 1'b1)]));
                eaddr = ea + AW'(2);
                chk("addr_hold", 32'(rom_addr), 32'(eaddr));
            end else begin
                eaddr = ea + AW'(gap - 1);
                chk("addr_fetch", 32'(rom_addr), 32'(eaddr));
            end

            case (mode)
                0: op_ready = 1'b1;
                1: op_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (exp_v && stall < 5) begin
                        op_ready = 1'b0;
                        stall++;
                    end else begin
                        op_ready = 1'b1;
                    end
                end
            endcase

            if ((inject == 1 && cyc == 4) ||
                (inject == 2 && exp_v && op_ready && k == n - 1)) begin
                start = 1'b1;
                base  = AW'(100);
                count = CW'(3);
            end

            if (exp_v && op_ready) begin
                k++;
                gap   = 0;
                stall = 0;
            end
            @(negedge clk);
            gap++;
            cyc++;
        end
        start    = 1'b0;
        op_ready = 1'b0;

        if (k < n) begin
            chk("timeout", 32'd0, 32'd1);
            return;
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_valid", 32'(op_valid), 32'd0);
        @(negedge clk);
        chk("end_done", 32'(done), 32'd0);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_valid", 32'(op_valid), 32'd0);
    endtask

    initial begin
        int seen;
        int budget;

        for (int i = 0; i < (1 << AW); i++) rom[i] = DW'($urandom);
        rom[0]   = 16'h7FFF;
        rom[1]   = 16'h0C88;
        rom[510] = 16'h0336;
        rom[511] = 16'hF378;
        rom[18]  = 16'h8000;
        rom[19]  = 16'h0000;

        rst = 1'b1; start = 1'b0; op_ready = 1'b0; base = '0; count = '0;
        repeat (2) @(negedge clk);
        chk("rst_addr", 32'(rom_addr), 32'd0);
        chk("rst_a", 32'(op_a), 32'd0);
        chk("rst_b", 32'(op_b), 32'd0);
        chk("rst_valid", 32'(op_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_cmd(AW'(0), 1, 0, 0);
        chk("idle_hold_a", 32'(op_a), 32'h7FFF);
        chk("idle_hold_b", 32'(op_b), 32'h0C88);

        run_cmd(AW'(510), 2, 0, 0);
        run_cmd(AW'(18), 1, 2, 0);
        chk("stall_a_final", 32'(op_a), 32'h8000);
        run_cmd(AW'(7), 0, 0, 0);
        run_cmd(AW'(0), 4, 0, 1);
        run_cmd(AW'(30), 3, 1, 2);

        // Reset in the middle of a command, at the second offered pair.
        start = 1'b1; base = '0; count = CW'(5); op_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0; budget = 0;
        while (seen < 2 && budget < 50) begin
            if (op_valid) seen++;
            if (seen < 2) begin
                @(negedge clk);
                budget++;
            end
        end
        chk("rst_mid_reach", 32'(seen), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        chk("rstm_addr", 32'(rom_addr), 32'd0);
        chk("rstm_a", 32'(op_a), 32'd0);
        chk("rstm_b", 32'(op_b), 32'd0);
        chk("rstm_valid", 32'(op_valid), 32'd0);
        chk("rstm_busy", 32'(busy), 32'd0);
        chk("rstm_done", 32'(done), 32'd0);
        rst = 1'b0; op_ready = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_done", 32'(done), 32'd0);
            chk("post_rst_valid", 32'(op_valid), 32'd0);
        end
        run_cmd(AW'(18), 1, 0, 0);

        // Randomized commands, including ones that cross the wrap point.
        for (int t = 0; t < 10; t++) begin
            logic [AW-1:0] rb;
            rb = (t % 3 == 0) ? AW'($urandom_range(500, 511)) : AW'($urandom);
            run_cmd(rb, $urandom_range(0, 6), $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
